// File: rtl/tpu_host_sequencer_if.sv
// Host/TPU-facing signal bundle of tpu_host_sequencer: row stream in, buffer write port, start/done, result stream out.
// The master modport is the sequencer side; the slave modport is the host + mini_tpu_top side.
interface tpu_host_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 64
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              tpu_we;
    logic [ADDR_W-1:0] tpu_write_addr;
    logic [DATA_W-1:0] tpu_write_data;
    logic              tpu_start;
    logic              tpu_done;
    logic [OUT_W-1:0]  tpu_final_out;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;

    modport master (
        input  s_valid, s_data, tpu_done, tpu_final_out, m_ready,
        output s_ready, tpu_we, tpu_write_addr, tpu_write_data, tpu_start, m_valid, m_data
    );

    modport slave (
        output s_valid, s_data, tpu_done, tpu_final_out, m_ready,
        input  s_ready, tpu_we, tpu_write_addr, tpu_write_data, tpu_start, m_valid, m_data
    );
endinterface

// File: rtl/tpu_host_sequencer.sv
// Job sequencer feeding mini_tpu_top: loads NUM_ROWS rows into the unified buffer, starts the TPU, returns final_out.
// Optional WAIT watchdog with sticky err flag is enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_host_sequencer #(
    parameter int NUM_ROWS       = 4,
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int OUT_W          = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tpu_host_sequencer_if.master bus,
    output logic                 busy,
    output logic [7:0]           job_count,
    output logic                 err
);
    if (NUM_ROWS < 1 || NUM_ROWS > (1 << ADDR_W) || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("tpu_host_sequencer: NUM_ROWS or TIMEOUT_CYCLES out of range");
    end

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

`ifdef TPU_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {ST_LOAD, ST_FLUSH, ST_START, ST_WAIT, ST_OUT, ST_ERR} state_t;
    // Compared before the increment, so the watchdog fires after exactly TIMEOUT_CYCLES WAIT cycles.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]        wait_cnt_reg;
    logic              err_reg;
`else
    typedef enum logic [2:0] {ST_LOAD, ST_FLUSH, ST_START, ST_WAIT, ST_OUT} state_t;
`endif

    state_t            state_reg;
    logic [ADDR_W-1:0] row_cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              start_reg;
    logic              m_valid_reg;
    logic [OUT_W-1:0]  m_data_reg;
    logic [7:0]        job_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_LOAD;
            row_cnt_reg   <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            start_reg     <= 1'b0;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            job_count_reg <= '0;
`ifdef TPU_SEQ_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            we_reg    <= 1'b0;
            start_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    // s_ready is 1 throughout LOAD, so s_valid alone marks a handshake.
                    if (bus.s_valid) begin
                        we_reg   <= 1'b1;
                        addr_reg <= row_cnt_reg;
                        data_reg <= bus.s_data;
                        if (row_cnt_reg == LAST_ROW) begin
                            row_cnt_reg <= '0;
                            state_reg   <= ST_FLUSH;
                        end else begin
                            row_cnt_reg <= row_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    start_reg <= 1'b1;
                    state_reg <= ST_START;
                end
                ST_START: begin
                    // A done left high by the previous job must not be captured, so START never looks at it.
`ifdef TPU_SEQ_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tpu_done) begin
                        m_data_reg  <= bus.tpu_final_out;
                        m_valid_reg <= 1'b1;
                        state_reg   <= ST_OUT;
`ifdef TPU_SEQ_TIMEOUT_EN
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
`endif
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_reg   <= 1'b0;
                        job_count_reg <= job_count_reg + 8'd1;
                        state_reg     <= ST_LOAD;
                    end
                end
`ifdef TPU_SEQ_TIMEOUT_EN
                ST_ERR: begin
                    state_reg <= ST_LOAD;
                end
`endif
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.s_ready        = (state_reg == ST_LOAD);
    assign bus.tpu_we         = we_reg;
    assign bus.tpu_write_addr = addr_reg;
    assign bus.tpu_write_data = data_reg;
    assign bus.tpu_start      = start_reg;
    assign bus.m_valid        = m_valid_reg;
    assign bus.m_data         = m_data_reg;
    assign busy               = !((state_reg == ST_LOAD) && (row_cnt_reg == '0));
    assign job_count          = job_count_reg;
`ifdef TPU_SEQ_TIMEOUT_EN
    assign err                = err_reg;
`else
    assign err                = 1'b0;
`endif
endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Randomized bench for tpu_host_sequencer: host driver, behavioural mini_tpu model and job-level scoreboard.
// All activity is sampled and driven just after the falling edge, one call to step() per clock cycle.
module tb_tpu_host_sequencer;
    localparam int NUM_ROWS       = 4;
    localparam int ADDR_W         = 4;
    localparam int DATA_W         = 32;
    localparam int OUT_W          = 64;
    localparam int TIMEOUT_CYCLES = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       err;
    logic [7:0] job_count;

    tpu_host_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    tpu_host_sequencer #(
        .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .job_count(job_count), .err(err)
    );

    always #5 clk = ~clk;

    int          n_vec, n_err, cyc, exp_count;
    logic [31:0] buf_mem [1 << ADDR_W];
    logic [31:0] rows [NUM_ROWS];
    int          wr_addr_q[$], wr_cyc_q[$], hs_cyc_q[$];
    logic [31:0] wr_data_q[$];
    int          start_cnt, start_cyc, lat, pend;
    bit          ident_mode, glitch;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Order-sensitive digest of a job's rows; stands in for the TPU computation.
    function automatic logic [63:0] job_result(input logic [31:0] r [NUM_ROWS]);
        logic [63:0] acc = 64'h9E37_79B9_7F4A_7C15;
        for (int i = 0; i < NUM_ROWS; i++)
            acc = (acc ^ {32'(i), r[i]}) * 64'd1099511628211;
        return acc;
    endfunction

    function automatic logic [63:0] tpu_out();
        logic [31:0] snap [NUM_ROWS];
        for (int i = 0; i < NUM_ROWS; i++) snap[i] = buf_mem[i];
        return ident_mode ? 64'h0000_0001_0000_0001 : job_result(snap);
    endfunction

    // One clock cycle: observe the DUT, then advance the TPU model (buffer writes, start, done latency).
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.tpu_we) begin
            buf_mem[bus.tpu_write_addr] = bus.tpu_write_data;
            wr_addr_q.push_back(int'(bus.tpu_write_addr));
            wr_data_q.push_back(bus.tpu_write_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.tpu_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (lat == 0) begin
                bus.tpu_done      = 1'b1;
                bus.tpu_final_out = tpu_out();
                pend = 0;
            end else begin
                bus.tpu_done = 1'b0;
                pend = lat;
            end
        end else if (glitch) begin
            bus.tpu_done      = 1'($urandom_range(0, 1));
            bus.tpu_final_out = {$urandom, $urandom};
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.tpu_done      = 1'b1;
                bus.tpu_final_out = tpu_out();
            end
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_s_ready"}, bus.s_ready, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_job_count"}, job_count, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_tpu_we"}, bus.tpu_we, 0);
        check({pfx, "_tpu_start"}, bus.tpu_start, 0);
        check({pfx, "_m_valid"}, bus.m_valid, 0);
        check({pfx, "_addr"}, bus.tpu_write_addr, 0);
        check({pfx, "_wdata"}, bus.tpu_write_data, 0);
        check({pfx, "_m_data"}, bus.m_data, 0);
    endtask

    // mode 0: s_valid always high, 1: toggles every cycle, 2: random.
    task automatic feed_rows(input int mode, input int n, output int first_hs, output int last_hs);
        int idx, guard;
        bit v, hs;
        idx = 0; guard = 0; first_hs = -1; last_hs = -1;
        while (idx < n && guard < 64) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.s_valid = v;
            bus.s_data  = v ? rows[idx] : $urandom;
            hs = v && bus.s_ready;
            if (hs) begin
                hs_cyc_q.push_back(cyc);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            step();
            if (hs) begin
                idx++;
                if (idx < n) check("busy_mid_load", busy, 1);
            end
            guard++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        check("rows_accepted", idx, n);
    endtask

    task automatic clear_job_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); hs_cyc_q.delete();
        start_cnt = 0; start_cyc = -1;
    endtask

    task automatic run_job(input int mode, input int stall, input int lat_i, input bit ident, output int first_hs);
        int          last_hs, guard, exp_mv;
        logic [63:0] exp_res;
        for (int i = 0; i < NUM_ROWS; i++) rows[i] = ident ? (32'h1 << (8 * i)) : $urandom;
        exp_res = ident ? 64'h0000_0001_0000_0001 : job_result(rows);
        clear_job_logs();
        lat = lat_i; ident_mode = ident; glitch = 1'b0;
        bus.m_ready = (stall == 0);
        check("idle_busy", busy, 0);
        check("idle_s_ready", bus.s_ready, 1);
        feed_rows(mode, NUM_ROWS, first_hs, last_hs);
        check("flush_s_ready", bus.s_ready, 0);
        guard = 0;
        while (!bus.m_valid && guard < 64) begin
            step();
            guard++;
        end
        check("m_valid_seen", bus.m_valid, 1);
        // done is never taken in START, so even a zero-latency TPU costs one extra cycle.
        exp_mv = start_cyc + ((lat_i > 1) ? lat_i : 1) + 1;
        check("start_count", start_cnt, 1);
        check("start_cycle", start_cyc, last_hs + 2);
        check("m_valid_cycle", cyc, exp_mv);
        check("m_data", bus.m_data, exp_res);
        check("write_count", wr_addr_q.size(), NUM_ROWS);
        for (int i = 0; i < NUM_ROWS && i < wr_addr_q.size(); i++) begin
            check("write_addr", wr_addr_q[i], i);
            check("write_data", wr_data_q[i], rows[i]);
            check("write_cycle", wr_cyc_q[i], hs_cyc_q[i] + 1);
        end
        glitch = (stall > 0);
        for (int k = 0; k < stall; k++) begin
            step();
            check("stall_m_valid", bus.m_valid, 1);
            check("stall_m_data", bus.m_data, exp_res);
            check("stall_s_ready", bus.s_ready, 0);
        end
        glitch = 1'b0;
        bus.m_ready = 1'b1;
        step();
        exp_count = (exp_count + 1) % 256;
        check("post_m_valid", bus.m_valid, 0);
        check("post_s_ready", bus.s_ready, 1);
        check("post_busy", busy, 0);
        check("job_count", job_count, exp_count);
        $display("job mode=%0d stall=%0d lat=%0d result=%h job_count=%0d", mode, stall, lat_i, bus.m_data, job_count);
    endtask

    int fh, lh, prev_fh;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; exp_count = 0;
        lat = 0; pend = 0; glitch = 1'b0; ident_mode = 1'b0;
        clear_job_logs();
        for (int i = 0; i < (1 << ADDR_W); i++) buf_mem[i] = '0;
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        // Stale done with a junk result: must not be captured in START of the first job.
        bus.tpu_done = 1'b1; bus.tpu_final_out = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        check_reset("rst");
        step();
        rst_n = 1'b1;

        run_job(0, 0, 0, 1'b1, fh);
        run_job(1, 0, 2, 1'b0, fh);
        run_job(0, 10, 1, 1'b0, fh);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, fh);

        for (int i = 0; i < NUM_ROWS; i++) rows[i] = $urandom;
        clear_job_logs();
        feed_rows(0, 2, fh, lh);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        step();
        step();
        check("midrst_no_start", start_cnt, 0);
        rst_n = 1'b1;
        exp_count = 0;

        prev_fh = -1;
        for (int j = 0; j < 256; j++) begin
            run_job(0, 0, 0, 1'b0, fh);
            if (j > 0) check("job_spacing", fh - prev_fh, NUM_ROWS + 4);
            prev_fh = fh;
        end
        check("job_count_wrap", job_count, 8'd0);

`ifdef TPU_SEQ_TIMEOUT_EN
        begin
            int  guard;
            bit  saw_mv;
            for (int i = 0; i < NUM_ROWS; i++) rows[i] = $urandom;
            clear_job_logs();
            lat = -1; glitch = 1'b0; ident_mode = 1'b0; bus.m_ready = 1'b1;
            feed_rows(0, NUM_ROWS, fh, lh);
            guard = 0; saw_mv = 1'b0;
            while (!err && guard < 400) begin
                step();
                if (bus.m_valid) saw_mv = 1'b1;
                guard++;
            end
            check("timeout_err", err, 1);
            check("timeout_cycle", cyc, start_cyc + 1 + TIMEOUT_CYCLES);
            check("timeout_no_m_valid", saw_mv, 0);
            step();
            check("timeout_s_ready", bus.s_ready, 1);
            check("timeout_job_count", job_count, exp_count);
            check("timeout_err_sticky", err, 1);
            $display("job timeout err=%0d job_count=%0d", err, job_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
